// File: rtl/pipeline_decode_ctrl_if.sv
// Decode-stage bus between the IF/ID register, the decode controller and the ID/EX controls.
// Handshake: instr is consumed at a rising edge only when stall_out=0 and stall_in=0; otherwise the source holds it.
interface pipeline_decode_ctrl_if #(
  parameter int INSTR_W = 16
);
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic               stall_in;
  logic               zero;
  logic [3:0]         alu_cmd;
  logic               rf_write_back_en;
  logic               write_back_result_mux;
  logic               mem_write_en;
  logic               rf_write_dest_mux;
  logic               add_2_mux;
  logic               data_2_mux;
  logic               mem_write_mux;
  logic               branch_en;
  logic               jump;
  logic               stall_out;
  logic               illegal;

  modport master (
    output instr_valid, instr, stall_in, zero,
    input  alu_cmd, rf_write_back_en, write_back_result_mux, mem_write_en,
           rf_write_dest_mux, add_2_mux, data_2_mux, mem_write_mux,
           branch_en, jump, stall_out, illegal
  );

  modport slave (
    input  instr_valid, instr, stall_in, zero,
    output alu_cmd, rf_write_back_en, write_back_result_mux, mem_write_en,
           rf_write_dest_mux, add_2_mux, data_2_mux, mem_write_mux,
           branch_en, jump, stall_out, illegal
  );
endinterface

// File: rtl/pipeline_decode_ctrl.sv
// Registered decode controller: opcode decode, load-use bubble, branch/jump squash.
// Optional MUL_STALL_EN macro adds a multi-cycle multiply sequence (MUL_WAIT state).
module pipeline_decode_ctrl #(
  parameter int INSTR_W    = 16,
  parameter int OP_W       = 4,
  parameter int REG_W      = 4,
  parameter int MUL_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_decode_ctrl_if.slave bus,
  output logic [1:0]            state_o
);

  if (INSTR_W < OP_W + 3 * REG_W || MUL_CYCLES < 2) begin : g_bad_params
    $error("pipeline_decode_ctrl: illegal parameter combination");
  end

  typedef struct packed {
    logic [3:0] alu_cmd;
    logic       rf_write_back_en;
    logic       write_back_result_mux;
    logic       mem_write_en;
    logic       rf_write_dest_mux;
    logic       add_2_mux;
    logic       data_2_mux;
    logic       mem_write_mux;
    logic       branch_en;
    logic       jump;
    logic       illegal;
  } ctrl_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SQUASH = 2'd1
`ifdef MUL_STALL_EN
    , MUL_WAIT = 2'd2
`endif
  } state_e;

  localparam int OP_LSB = INSTR_W - OP_W;

  state_e             state_q, state_d;
  ctrl_t              ctrl_q, ctrl_d, dec;
  logic               prev_ld_q, prev_ld_d;
  logic [REG_W-1:0]   prev_rd_q, prev_rd_d;
  logic               stall_out;
  logic [OP_W-1:0]    op;
  logic [31:0]        opn;
  logic [REG_W-1:0]   rd, rs1, rs2, src2;
  logic               use1, use2, hazard;
`ifdef MUL_STALL_EN
  localparam int CNT_W = $clog2(MUL_CYCLES);
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

  function automatic ctrl_t decode(input logic [31:0] o, input logic z);
    ctrl_t c;
    c = '0;
    case (o)
      32'd0: ;
      32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9: begin
        c.alu_cmd           = o[3:0];
        c.rf_write_back_en  = 1'b1;
        c.rf_write_dest_mux = 1'b1;
      end
      32'd10, 32'd11: begin
        c.alu_cmd               = 4'd1;
        c.rf_write_back_en      = 1'b1;
        c.data_2_mux            = 1'b1;
        c.rf_write_dest_mux     = 1'b1;
        c.write_back_result_mux = (o == 32'd11);
      end
      32'd12: begin
        c.alu_cmd       = 4'd1;
        c.data_2_mux    = 1'b1;
        c.add_2_mux     = 1'b1;
        c.mem_write_mux = 1'b1;
        c.mem_write_en  = 1'b1;
      end
      32'd13: c.branch_en = z;
      32'd14: c.jump      = 1'b1;
      default: c.illegal  = 1'b1;
    endcase
    return c;
  endfunction

  assign op   = bus.instr[INSTR_W-1 -: OP_W];
  assign opn  = 32'(op);
  assign rd   = bus.instr[OP_LSB-1 -: REG_W];
  assign rs1  = bus.instr[OP_LSB-1-REG_W -: REG_W];
  assign rs2  = bus.instr[OP_LSB-1-2*REG_W -: REG_W];
  // A store reads rd as its data source, so it takes the second-source slot.
  assign src2 = (opn == 32'd12) ? rd : rs2;
  assign use1 = (opn >= 32'd1) && (opn <= 32'd12);
  assign use2 = ((opn >= 32'd1) && (opn <= 32'd9)) || (opn == 32'd12);
  assign hazard = bus.instr_valid && prev_ld_q &&
                  ((use1 && (rs1 == prev_rd_q)) || (use2 && (src2 == prev_rd_q)));
  assign dec  = decode(bus.instr_valid ? opn : 32'd0, bus.zero);

  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    prev_ld_d = prev_ld_q;
    prev_rd_d = prev_rd_q;
    stall_out = 1'b0;
`ifdef MUL_STALL_EN
    cnt_d     = cnt_q;
`endif
    if (!bus.stall_in) begin
      case (state_q)
        RUN: begin
          if (hazard) begin
            stall_out = 1'b1;
            ctrl_d    = '0;
            prev_ld_d = 1'b0;
          end else begin
            ctrl_d    = dec;
            prev_ld_d = bus.instr_valid && (opn == 32'd11);
            prev_rd_d = rd;
            if (bus.instr_valid && ((opn == 32'd14) || ((opn == 32'd13) && bus.zero)))
              state_d = SQUASH;
`ifdef MUL_STALL_EN
            if (bus.instr_valid && (opn == 32'd9)) begin
              ctrl_d.rf_write_back_en  = 1'b0;
              ctrl_d.rf_write_dest_mux = 1'b0;
              state_d                  = MUL_WAIT;
              cnt_d                    = CNT_W'(1);
            end
`endif
          end
        end
        SQUASH: begin
          ctrl_d  = '0;
          state_d = RUN;
        end
`ifdef MUL_STALL_EN
        MUL_WAIT: begin
          // Back in RUN for the final multiply cycle so the held instruction issues right after it.
          stall_out      = 1'b1;
          ctrl_d         = '0;
          ctrl_d.alu_cmd = 4'd9;
          if (cnt_q == CNT_W'(MUL_CYCLES - 1)) begin
            ctrl_d.rf_write_back_en  = 1'b1;
            ctrl_d.rf_write_dest_mux = 1'b1;
            state_d                  = RUN;
            cnt_d                    = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`endif
        default: begin
          ctrl_d  = '0;
          state_d = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      ctrl_q    <= '0;
      prev_ld_q <= 1'b0;
      prev_rd_q <= '0;
`ifdef MUL_STALL_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      prev_ld_q <= prev_ld_d;
      prev_rd_q <= prev_rd_d;
`ifdef MUL_STALL_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign state_o                   = state_q;
  assign bus.stall_out             = stall_out;
  assign bus.alu_cmd               = ctrl_q.alu_cmd;
  assign bus.rf_write_back_en      = ctrl_q.rf_write_back_en;
  assign bus.write_back_result_mux = ctrl_q.write_back_result_mux;
  assign bus.mem_write_en          = ctrl_q.mem_write_en;
  assign bus.rf_write_dest_mux     = ctrl_q.rf_write_dest_mux;
  assign bus.add_2_mux             = ctrl_q.add_2_mux;
  assign bus.data_2_mux            = ctrl_q.data_2_mux;
  assign bus.mem_write_mux         = ctrl_q.mem_write_mux;
  assign bus.branch_en             = ctrl_q.branch_en;
  assign bus.jump                  = ctrl_q.jump;
  assign bus.illegal               = ctrl_q.illegal;

endmodule

// File: tb/tb_pipeline_decode_ctrl.sv
// Bench for pipeline_decode_ctrl: directed literal checks plus randomized traffic against
// a slot-schedule reference model compared every cycle.
module tb_pipeline_decode_ctrl;
  localparam int INSTR_W    = 16;
  localparam int OP_W       = 4;
  localparam int REG_W      = 4;
  localparam int MUL_CYCLES = 4;
  localparam int CW         = 14;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] state_o;
  always #5 clk = ~clk;

  pipeline_decode_ctrl_if #(.INSTR_W(INSTR_W)) bus();

  pipeline_decode_ctrl #(
    .INSTR_W(INSTR_W), .OP_W(OP_W), .REG_W(REG_W), .MUL_CYCLES(MUL_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_o(state_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Control vector: {alu_cmd, wb_en, wb_res_mux, mem_we, dest_mux, add2, data2, mem_wmux, branch, jump, illegal}
  function automatic logic [CW-1:0] ctl(input int alu, input bit wb, input bit wres, input bit mwe,
                                        input bit dest, input bit add2, input bit d2, input bit mwm,
                                        input bit br, input bit jmp, input bit ill);
    logic [3:0] a;
    a = alu[3:0];
    return {a, wb, wres, mwe, dest, add2, d2, mwm, br, jmp, ill};
  endfunction

  function automatic logic [CW-1:0] dut_ctrl();
    return {bus.alu_cmd, bus.rf_write_back_en, bus.write_back_result_mux, bus.mem_write_en,
            bus.rf_write_dest_mux, bus.add_2_mux, bus.data_2_mux, bus.mem_write_mux,
            bus.branch_en, bus.jump, bus.illegal};
  endfunction

  function automatic logic [15:0] mk(input int op, input int rd, input int r1, input int r2);
    logic [3:0] a, b, c, d;
    a = op[3:0]; b = rd[3:0]; c = r1[3:0]; d = r2[3:0];
    return {a, b, c, d};
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [CW-1:0] spec_ctrl(input int op, input bit z);
    if (op == 0)       return '0;
    else if (op <= 9)  return ctl(op, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    else if (op == 10) return ctl(1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    else if (op == 11) return ctl(1, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0);
    else if (op == 12) return ctl(1, 0, 0, 1, 0, 1, 1, 1, 0, 0, 0);
    else if (op == 13) return ctl(0, 0, 0, 0, 0, 0, 0, 0, z, 0, 0);
    else if (op == 14) return ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    else               return ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endfunction

  function automatic bit reads_reg(input logic [15:0] ins, input logic [3:0] r);
    int op;
    logic [3:0] srcs[$];
    op = int'(ins[15:12]);
    if (op >= 1 && op <= 9) begin srcs.push_back(ins[7:4]); srcs.push_back(ins[3:0]); end
    if (op == 10 || op == 11) srcs.push_back(ins[7:4]);
    if (op == 12) begin srcs.push_back(ins[7:4]); srcs.push_back(ins[11:8]); end
    foreach (srcs[k]) if (srcs[k] == r) return 1'b1;
    return 1'b0;
  endfunction

  // Forced future slots: {stall_out during the slot, control vector issued at its end}
  logic [CW:0]   exp_q[$];
  logic [CW-1:0] exp_cur = '0;
  bit            m_prev_ld = 1'b0;
  logic [3:0]    m_prev_rd = '0;
  bit            last_stall = 1'b0;

  function automatic bit m_hazard();
    return bus.instr_valid && m_prev_ld && reads_reg(bus.instr, m_prev_rd);
  endfunction

  function automatic bit m_stall();
    if (bus.stall_in) return 1'b0;
    if (exp_q.size() != 0) return exp_q[0][CW];
    return m_hazard();
  endfunction

  task automatic model_step();
    int op;
    logic [CW:0] e;
    if (rst) begin
      exp_q.delete(); exp_cur = '0; m_prev_ld = 1'b0; m_prev_rd = '0;
      return;
    end
    if (bus.stall_in) return;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      exp_cur = e[CW-1:0];
      m_prev_ld = 1'b0;
      return;
    end
    if (m_hazard()) begin
      exp_cur = '0;
      m_prev_ld = 1'b0;
      return;
    end
    op = bus.instr_valid ? int'(bus.instr[15:12]) : 0;
    exp_cur   = spec_ctrl(op, bus.zero);
    m_prev_ld = (op == 11);
    m_prev_rd = bus.instr[11:8];
    if (op == 14 || (op == 13 && bus.zero)) exp_q.push_back({1'b0, {CW{1'b0}}});
`ifdef MUL_STALL_EN
    if (op == 9) begin
      exp_cur = ctl(9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 1; k < MUL_CYCLES; k++)
        exp_q.push_back({1'b1, (k == MUL_CYCLES - 1) ? ctl(9, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0)
                                                      : ctl(9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
    end
`endif
  endtask

  always @(posedge clk) model_step();

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (rst) begin
      check("rst_ctrl", 32'(dut_ctrl()), 32'd0);
      check("rst_stall", 32'(bus.stall_out), 32'd0);
    end else begin
      check("ctrl", 32'(dut_ctrl()), 32'(exp_cur));
      check("stall_out", 32'(bus.stall_out), 32'(m_stall()));
    end
    last_stall = bus.stall_out;
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input logic [15:0] ins, input bit z, input bit si);
    bus.instr_valid = v;
    bus.instr       = ins;
    bus.zero        = z;
    bus.stall_in    = si;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle_check_stall(input string name, input bit exp);
    #1;
    check(name, 32'(bus.stall_out), 32'(exp));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  logic [CW-1:0] OP1_C;
  logic [CW-1:0] LD_C;
  logic [CW-1:0] MUL_C;
  logic [CW-1:0] MULWB_C;

  initial begin
    bit si_prev;
    OP1_C   = ctl(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    LD_C    = ctl(1, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0);
    MUL_C   = ctl(9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    MULWB_C = ctl(9, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);

    // Reset with garbage on the bus
    drive(1, 16'hFFFF, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'(dut_ctrl()), 32'd0);
    check("reset_stall", 32'(bus.stall_out), 32'd0);
    rst = 1'b0;

    drive(1, mk(1, 3, 1, 2), 0, 0);
    tick(); check("op1_issue", 32'(dut_ctrl()), 32'(OP1_C));

    // Load-use on rs1
    drive(1, mk(11, 3, 0, 0), 0, 0);
    tick(); check("ld_issue", 32'(dut_ctrl()), 32'(LD_C));
    drive(1, mk(1, 4, 3, 5), 0, 0);
    settle_check_stall("lu_stall", 1);
    tick(); check("lu_bubble", 32'(dut_ctrl()), 32'd0);
    settle_check_stall("lu_release", 0);
    tick(); check("lu_add_issue", 32'(dut_ctrl()), 32'(OP1_C));

    // No hazard when the load target is not read
    drive(1, mk(11, 3, 0, 0), 0, 0);
    tick();
    drive(1, mk(1, 4, 1, 5), 0, 0);
    settle_check_stall("no_lu_stall", 0);
    tick(); check("no_lu_issue", 32'(dut_ctrl()), 32'(OP1_C));

    // Taken branch squashes the next slot
    drive(1, mk(13, 0, 0, 0), 1, 0);
    tick(); check("bz_taken", 32'(dut_ctrl()), 32'(ctl(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)));
    drive(1, mk(1, 6, 7, 8), 0, 0);
    settle_check_stall("squash_stall", 0);
    tick(); check("squashed_slot", 32'(dut_ctrl()), 32'd0);
    tick(); check("after_squash", 32'(dut_ctrl()), 32'(OP1_C));

    // Not-taken branch
    drive(1, mk(13, 0, 0, 0), 0, 0);
    tick(); check("bz_not_taken", 32'(dut_ctrl()), 32'd0);
    drive(1, mk(1, 6, 7, 8), 0, 0);
    tick(); check("bz_nt_next", 32'(dut_ctrl()), 32'(OP1_C));

    // Illegal opcode pulse
    drive(1, mk(15, 1, 2, 3), 0, 0);
    tick(); check("illegal", 32'(dut_ctrl()), 32'(ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)));
    drive(0, mk(15, 1, 2, 3), 0, 0);
    tick(); check("illegal_pulse_end", 32'(dut_ctrl()), 32'd0);

    // stall_in freezes outputs after a load
    drive(1, mk(11, 2, 0, 0), 0, 0);
    tick(); check("ld2_issue", 32'(dut_ctrl()), 32'(LD_C));
    drive(1, mk(1, 6, 7, 8), 0, 1);
    for (int k = 0; k < 3; k++) begin
      settle_check_stall("hold_stall_out", 0);
      tick(); check("hold_frozen", 32'(dut_ctrl()), 32'(LD_C));
    end
    drive(1, mk(1, 6, 7, 8), 0, 0);
    tick(); check("hold_release", 32'(dut_ctrl()), 32'(OP1_C));

    // Multiply
    drive(1, mk(9, 5, 6, 7), 0, 0);
    tick();
`ifdef MUL_STALL_EN
    drive(1, mk(1, 6, 7, 8), 0, 0);
    for (int c = 1; c <= MUL_CYCLES; c++) begin
      check("mul_ctrl", 32'(dut_ctrl()), (c < MUL_CYCLES) ? 32'(MUL_C) : 32'(MULWB_C));
      settle_check_stall("mul_stall", c < MUL_CYCLES);
      tick();
    end
    check("mul_next", 32'(dut_ctrl()), 32'(OP1_C));
    drive(1, mk(9, 5, 6, 7), 0, 0);
    tick();
    drive(1, mk(1, 6, 7, 8), 0, 0);
    tick(); check("mul_c2", 32'(dut_ctrl()), 32'(MUL_C));
    rst = 1'b1;
    #1;
    check("mul_rst_ctrl", 32'(dut_ctrl()), 32'd0);
    check("mul_rst_state", 32'(state_o), 32'd0);
    tick();
    rst = 1'b0;
`else
    check("mul_single", 32'(dut_ctrl()), 32'(MULWB_C));
    drive(1, mk(1, 6, 7, 8), 0, 0);
    settle_check_stall("mul_single_stall", 0);
    tick(); check("mul_single_next", 32'(dut_ctrl()), 32'(OP1_C));
`endif

    // Randomized traffic; IF/ID holds its instruction while stalled
    si_prev = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      bit si, v, z;
      int op;
      logic [15:0] ins;
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      si = ($urandom_range(0, 9) == 0);
      z  = $urandom_range(0, 1) == 1;
      if (!(last_stall || si_prev)) begin
        op  = ($urandom_range(0, 3) == 0) ? 11 : int'($urandom_range(0, 15));
        v   = ($urandom_range(0, 7) != 0);
        ins = mk(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)));
        drive(v, ins, z, si);
      end else begin
        drive(bus.instr_valid, bus.instr, z, si);
      end
      si_prev = si;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
